// File: rtl/pulse_period_meter.sv
// Measures period and high time of a slow square wave in clk cycles, with a sticky loss-of-signal flag.
// Optional 3-sample input stability filter: define PULSE_PERIOD_METER_DEGLITCH_EN.
module pulse_period_meter #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_sig,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             period_valid,
   output logic             timeout,
   output logic             measuring
);

   typedef enum logic [0:0] {StIdle, StMeasure} state_e;

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

   logic r_sync1, r_sync2, r_lvl;
   logic w_lvl, w_rise, w_fall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_lvl   <= 1'b0;
      end else begin
         r_sync1 <= in_sig;
         r_sync2 <= r_sync1;
         r_lvl   <= w_lvl;
      end
   end

`ifdef PULSE_PERIOD_METER_DEGLITCH_EN
   logic [1:0] r_hist;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hist <= 2'b00;
      end else begin
         r_hist <= {r_hist[0], r_sync2};
      end
   end

   // Level follows the synchronised input only once three samples in a row agree.
   assign w_lvl = (r_sync2 == r_hist[0] && r_hist[0] == r_hist[1]) ? r_sync2 : r_lvl;
`else
   assign w_lvl = r_sync2;
`endif

   assign w_rise = w_lvl & ~r_lvl;
   assign w_fall = ~w_lvl & r_lvl;

   state_e           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [CNT_W-1:0] r_hi_cap, w_hi_cap_nxt;
   logic             r_fall_seen, w_fall_seen_nxt;
   logic [CNT_W-1:0] r_period, w_period_nxt;
   logic [CNT_W-1:0] r_high, w_high_nxt;
   logic             r_valid, w_valid_nxt;
   logic             r_timeout, w_timeout_nxt;

   assign w_cnt_inc = r_cnt + CNT_W'(1);

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_hi_cap_nxt    = r_hi_cap;
      w_fall_seen_nxt = r_fall_seen;
      w_period_nxt    = r_period;
      w_high_nxt      = r_high;
      w_valid_nxt     = 1'b0;
      w_timeout_nxt   = r_timeout;
      unique case (r_state)
         StIdle: begin
            w_cnt_nxt = '0;
            if (w_rise) begin
               w_state_nxt     = StMeasure;
               w_fall_seen_nxt = 1'b0;
            end
         end
         StMeasure: begin
            if (w_rise) begin
               // A rise on the last allowed count still completes a measurement.
               w_period_nxt    = w_cnt_inc;
               w_high_nxt      = r_fall_seen ? r_hi_cap : w_cnt_inc;
               w_valid_nxt     = 1'b1;
               w_timeout_nxt   = 1'b0;
               w_cnt_nxt       = '0;
               w_fall_seen_nxt = 1'b0;
            end else if (r_cnt == CntLast) begin
               w_state_nxt   = StIdle;
               w_timeout_nxt = 1'b1;
               w_cnt_nxt     = '0;
            end else begin
               w_cnt_nxt = w_cnt_inc;
               if (w_fall) begin
                  w_hi_cap_nxt    = w_cnt_inc;
                  w_fall_seen_nxt = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_hi_cap    <= '0;
         r_fall_seen <= 1'b0;
         r_period    <= '0;
         r_high      <= '0;
         r_valid     <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_hi_cap    <= w_hi_cap_nxt;
         r_fall_seen <= w_fall_seen_nxt;
         r_period    <= w_period_nxt;
         r_high      <= w_high_nxt;
         r_valid     <= w_valid_nxt;
         r_timeout   <= w_timeout_nxt;
      end
   end

   assign period       = r_period;
   assign high_time    = r_high;
   assign period_valid = r_valid;
   assign timeout      = r_timeout;
   assign measuring    = (r_state == StMeasure);

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed self-checking bench for pulse_period_meter (TIMEOUT = 200).
// Expectations follow PULSE_PERIOD_METER_DEGLITCH_EN when defined.
module tb_pulse_period_meter;

   localparam int unsigned CntW    = 16;
   localparam int unsigned Timeout = 200;
`ifdef PULSE_PERIOD_METER_DEGLITCH_EN
   localparam int unsigned Lat = 5;
`else
   localparam int unsigned Lat = 3;
`endif

   logic            clk;
   logic            rst;
   logic            in_sig;
   logic [CntW-1:0] period;
   logic [CntW-1:0] high_time;
   logic            period_valid;
   logic            timeout;
   logic            measuring;

   pulse_period_meter #(
      .CNT_W   (CntW),
      .TIMEOUT (Timeout)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .in_sig       (in_sig),
      .period       (period),
      .high_time    (high_time),
      .period_valid (period_valid),
      .timeout      (timeout),
      .measuring    (measuring)
   );

   typedef struct packed {
      logic [15:0] per;
      logic [15:0] hi;
      int unsigned cyc;
   } vrec_t;

   vrec_t       vq[$];
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   int exp_p[10] = '{50, 50, 50, 50, 100, 100, 100, 40, 20, 20};
   int exp_h[10] = '{25, 25, 25, 25, 30, 30, 30, 30, 10, 10};
`ifdef PULSE_PERIOD_METER_DEGLITCH_EN
   int g_n = 2;
   int g_p[3] = '{100, 100, 0};
   int g_h[3] = '{50, 50, 0};
`else
   int g_n = 3;
   int g_p[3] = '{70, 30, 100};
   int g_h[3] = '{50, 1, 50};
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (period_valid) vq.push_back('{per: period, hi: high_time, cyc: cyc});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Called at a negedge; holds the level for n cycles.
   task automatic drive(input logic lvl, input int n);
      in_sig = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic wave(input int h, input int l, input int n);
      repeat (n) begin
         drive(1'b1, h);
         drive(1'b0, l);
      end
   endtask

   initial begin
      int          k;
      int unsigned c0;
      int unsigned t_to;

      rst    = 1'b0;
      in_sig = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_period", 32'(period), 0);
      check("rst_high", 32'(high_time), 0);
      check("rst_valid", 32'(period_valid), 0);
      check("rst_timeout", 32'(timeout), 0);
      check("rst_measuring", 32'(measuring), 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Continuous stream: 25/25, then 30/70, a truncated period, then 10/10.
      vq.delete();
      wave(25, 25, 4);
      wave(30, 70, 3);
      drive(1'b1, 30);
      drive(1'b0, 10);
      wave(10, 10, 3);
      check("stream_count", 32'(vq.size()), 10);
      for (int i = 0; i < 10; i++) begin
         if (i < vq.size()) begin
            check($sformatf("stream_period[%0d]", i), 32'(vq[i].per), 32'(exp_p[i]));
            check($sformatf("stream_high[%0d]", i), 32'(vq[i].hi), 32'(exp_h[i]));
         end
      end
      if (vq.size() >= 10) begin
         check("spacing_50a", vq[1].cyc - vq[0].cyc, 50);
         check("spacing_50b", vq[2].cyc - vq[1].cyc, 50);
         check("spacing_100", vq[6].cyc - vq[5].cyc, 100);
      end
      check("stream_timeout", 32'(timeout), 0);

      // Loss of signal.
      k = 0;
      while (!timeout && k < 400) begin
         @(negedge clk);
         k++;
      end
      t_to = cyc;
      check("timeout_seen", 32'(timeout), 1);
      if (vq.size() >= 10) check("timeout_delay", t_to - vq[9].cyc, Timeout);
      check("timeout_measuring", 32'(measuring), 0);
      check("timeout_hold_period", 32'(period), 20);
      check("timeout_hold_high", 32'(high_time), 10);

      // Restart: arming rise, then 20-cycle period, then a period of exactly TIMEOUT.
      vq.delete();
      drive(1'b1, 10);
      check("rearm_timeout_sticky", 32'(timeout), 1);
      check("rearm_measuring", 32'(measuring), 1);
      check("rearm_no_valid", 32'(vq.size()), 0);
      drive(1'b0, 10);
      drive(1'b1, 10);
      drive(1'b0, 190);
      drive(1'b1, 10);
      drive(1'b0, 10);
      check("restart_count", 32'(vq.size()), 2);
      if (vq.size() >= 2) begin
         check("restart_period", 32'(vq[0].per), 20);
         check("restart_high", 32'(vq[0].hi), 10);
         check("edge_period", 32'(vq[1].per), Timeout);
         check("edge_high", 32'(vq[1].hi), 10);
      end
      check("edge_timeout", 32'(timeout), 0);

      // Reset mid-measurement.
      rst = 1'b0;
      #1;
      check("midrst_period", 32'(period), 0);
      check("midrst_high", 32'(high_time), 0);
      check("midrst_timeout", 32'(timeout), 0);
      check("midrst_measuring", 32'(measuring), 0);
      check("midrst_valid", 32'(period_valid), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      vq.delete();
      drive(1'b1, 25);
      drive(1'b0, 25);
      c0 = cyc;
      drive(1'b1, 25);
      drive(1'b0, 25);
      drive(1'b1, 10);
      drive(1'b0, 10);
      check("postrst_count", 32'(vq.size()), 2);
      if (vq.size() >= 2) begin
         check("postrst_latency", vq[0].cyc - c0, Lat);
         check("postrst_period0", 32'(vq[0].per), 50);
         check("postrst_high0", 32'(vq[0].hi), 25);
         check("postrst_period1", 32'(vq[1].per), 50);
      end
      drive(1'b0, 260);

      // 100-cycle waveform with a 1-clk high glitch in the low phase.
      vq.delete();
      drive(1'b1, 50);
      drive(1'b0, 20);
      drive(1'b1, 1);
      drive(1'b0, 29);
      drive(1'b1, 50);
      drive(1'b0, 50);
      drive(1'b1, 5);
      drive(1'b0, 10);
      check("glitch_count", 32'(vq.size()), 32'(g_n));
      for (int i = 0; i < 3; i++) begin
         if (i < g_n && i < vq.size()) begin
            check($sformatf("glitch_period[%0d]", i), 32'(vq[i].per), 32'(g_p[i]));
            check($sformatf("glitch_high[%0d]", i), 32'(vq[i].hi), 32'(g_h[i]));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
- Receive-side counterpart to the clock dividers: measures a slow square wave (divided clock, wheel/speed pulse, sensor tick) against the system clock.
- Reports period and high time in clk cycles, with a one-cycle valid strobe per completed period.
- Flags loss of signal with a sticky timeout.
- Used by the car-simulation control logic for speed and tick monitoring, and as a self-check on divider outputs.

Parameters:
- CNT_W, 16, width of the internal cycle counter and of the period/high_time outputs.
- TIMEOUT, 50000, number of clk cycles without a rising edge before timeout is declared. Must satisfy 2 <= TIMEOUT <= 2^CNT_W - 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- in_sig  input  1  measured signal; asynchronous to clk
- period  output  CNT_W  last measured rising-to-rising interval, in clk cycles
- high_time  output  CNT_W  last measured rising-to-falling interval, in clk cycles
- period_valid  output  1  one-cycle pulse when period/high_time update
- timeout  output  1  sticky loss-of-signal flag
- measuring  output  1  high while the FSM is in MEASURE

Behaviour:
- Reset is asynchronous, active-low, on rst; clock is clk.
- Reset values:
  - period = 0, high_time = 0
  - period_valid = 0, timeout = 0, measuring = 0
  - FSM = IDLE, counter = 0, synchroniser and edge register = 0
- Input path:
  - 2-flop synchroniser on in_sig, then one edge-detect register.
  - Rise/fall are detected on the synchronised signal.
  - Input-to-detect latency: 3 clk.
- FSM IDLE:
  - Counter held at 0.
  - Detected rise -> MEASURE, counter cleared to 0. No valid pulse is issued.
  - Falls are ignored.
- FSM MEASURE:
  - Counter increments by 1 every clk except in a rise cycle.
  - Detected fall: hi_cap <= counter + 1. hi_cap is an internal register.
  - Detected rise:
    - period <= counter + 1
    - high_time <= hi_cap
    - period_valid = 1 for that one cycle
    - timeout <= 0
    - counter <= 0
    - Stay in MEASURE.
  - No rise and counter == TIMEOUT - 1: go to IDLE, timeout <= 1, counter <= 0. period and high_time hold their last values.
  - Rise in the same cycle that counter reaches TIMEOUT - 1: the rise wins. Measurement is period = TIMEOUT, with no timeout.
  - If no fall occurred since the last rise (signal stuck high is impossible because of the timeout, but e.g. a rise following an undetected short low), high_time <= period value (100% duty).
- Arithmetic:
  - Counter + 1 cannot overflow because TIMEOUT <= 2^CNT_W - 1.
  - No saturation logic is required.
- Valid timing:
  - period_valid is asserted 3 clk after the in_sig rising edge at the pin (5 with DEGLITCH_EN).
  - Consecutive period_valid pulses are separated by exactly the measured period.
- Reset mid-measurement: all state returns to reset values immediately. The first rise after release only re-arms; it produces no valid pulse.
- measuring equals (state == MEASURE), registered with the state.

Optional Feature:
- Macro: PULSE_PERIOD_METER_DEGLITCH_EN.
- Defined:
  - A 3-sample stability filter sits after the synchroniser.
  - The filtered level changes only when 3 consecutive synchronised samples agree.
  - Pulses or gaps shorter than 3 clk are suppressed.
  - Detection latency rises to 5 clk.
  - Measured values for clean inputs are unchanged.
- Undefined: no filter; every synchronised transition counts. A 1-clk glitch produces a short period measurement.

Test Plan:
- Feed the output of a 50-cycle divider (25 high / 25 low) -> after the arming edge, period = 50, high_time = 25, period_valid every 50 clk, timeout = 0.
- Asymmetric input, 30 high / 70 low -> period = 100, high_time = 30; switch to 10/10 mid-stream -> the next valid after the change carries the mixed period, then period = 20, high_time = 10.
- TIMEOUT = 200, stop toggling in_sig -> timeout = 1 and measuring = 0 exactly 200 clk after the last detected rise; period holds the last value. Restart -> first rise gives no valid; the second gives a correct period and clears timeout.
- Rise arriving at counter == TIMEOUT - 1 -> period = TIMEOUT, period_valid = 1, timeout stays 0.
- Assert rst for 2 clk mid-period -> all outputs 0 immediately; the first rise after release gives no valid; the second gives the correct period.
- With PULSE_PERIOD_METER_DEGLITCH_EN, inject a 1-clk high glitch into a 100-cycle waveform -> period stays 100 and no extra valid. Without the macro -> a short period is reported.
